avalon_port_arbiter: RTL and testbench
======================================

Name: avalon_port_arbiter

Overview:
- Shares the single Avalon-MM master port between two requesters: the instruction-fetch port (read-only) and the data port (read/write) of the Harvard core.
- Runs one bus transaction at a time and arbitrates round-robin on conflict.
- Tracks `waitrequest`, registers read data, and drives a `stall` signal so the core freezes while any access is outstanding.
- Includes a watchdog that aborts hung transfers.

Parameters:
- TIMEOUT_CYCLES, 1024: max consecutive waitrequest-high cycles before a transfer is aborted; 0 disables the watchdog.
- CNT_W, 11: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request (level).
- i_addr  in  32  fetch byte address.
- i_rdata  out  32  fetched word; valid while i_ack=1.
- i_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request (level).
- d_write  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_be  in  4  byte enables.
- d_rdata  out  32  read data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for data.
- av_address  out  32  Avalon address.
- av_read  out  1  Avalon read strobe.
- av_write  out  1  Avalon write strobe.
- av_writedata  out  32  Avalon write data.
- av_byteenable  out  4  Avalon byte enables.
- av_waitrequest  in  1  slave stall.
- av_readdata  in  32  slave read data; valid in the cycle a read completes.
- stall  out  1  1 while any req is high and not yet acked.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, watchdog counter 0, last_grant=DATA (so the first tie goes to instr), timeout_err cleared. Reset mid-transfer abandons the transfer silently; no ack is issued.
- Requester contract: req plus its fields are held stable from assertion until the ack cycle. In the ack cycle the requester either drops req or presents the next request.
- States: IDLE, BUS_I, BUS_D. All Avalon outputs, acks and rdata are registered.
- IDLE:
  - Only i_req → BUS_I.
  - Only d_req → BUS_D.
  - Both → grant the requester that is not last_grant.
  - At the transition edge, load av_address/av_read/av_write/av_writedata/av_byteenable.
  - BUS_I drives av_read=1, av_byteenable=4'hF, av_write=0.
  - BUS_D drives av_read=~d_write, av_write=d_write, d_be, d_wdata.
- Ack-cycle mask: in the cycle a requester's ack is high, that requester's req is ignored in IDLE. This prevents a duplicate grant from a stale req. The other requester may be granted that cycle.
- BUS_x, av_waitrequest=1: hold all av_* outputs stable; increment watchdog.
- BUS_x, av_waitrequest=0: transfer completes this cycle. At the edge:
  - deassert av_read/av_write;
  - capture av_readdata into x_rdata (write: d_rdata unchanged);
  - pulse x_ack for exactly one cycle;
  - set last_grant=x, clear watchdog, → IDLE.
- Latency: req high in IDLE at cycle 0 → strobe at cycle 1 → ack at cycle 2 when waitrequest=0. Each waitrequest-high cycle adds 1. Back-to-back throughput is one transfer per 2 cycles minimum.
- Watchdog: if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES while waitrequest=1:
  - drop the strobes;
  - ack the requester with rdata=32'hFFFF_FFFF;
  - set timeout_err=1 (held until reset);
  - return to IDLE.
- stall = (i_req & ~i_ack) | (d_req & ~d_ack), combinational from inputs and registered acks.
- No address alignment checks; addresses pass through unchanged.
- An ack fires only on completion or timeout.

Test Plan:
- Single fetch: i_req=1, i_addr=0xBFC00000, waitrequest=0, readdata=0x24020005 → av_read=1 / av_address=0xBFC00000 in cycle 1; i_ack=1, i_rdata=0x24020005 in cycle 2; one av_read cycle total.
- Data write with wait states: d_req=1, d_write=1, d_addr=0x1000, d_wdata=0xDEADBEEF, d_be=4'b0011, waitrequest high for 3 cycles → av_write held with stable address/data/byteenable for 4 cycles; d_ack at cycle 5; stall=1 throughout until the ack cycle.
- Simultaneous requests after reset: i_req=d_req=1 → instr granted first, then data granted in the i_ack cycle. Next tie goes to instr again; each grant alternates and no requester is served twice consecutively while the other is waiting.
- Stale-req mask: hold i_req=1 through the ack cycle with d_req=0 → exactly one av_read for that fetch; a second fetch starts only from the cycle after the ack.
- Watchdog: TIMEOUT_CYCLES=4, waitrequest stuck at 1 on a data read → strobe drops after 4 wait cycles; d_ack=1 with d_rdata=0xFFFFFFFF; timeout_err=1 and stays set across later good transfers.
- Async reset mid-transfer: assert reset=0 between edges during BUS_D → av_read/av_write/acks/stall-related registers go to 0 immediately; no ack after release; the next request restarts normally.

Source files
------------

// File: rtl/avalon_port_arbiter.sv
// Round-robin share of one Avalon-MM master between the fetch and data ports.
// One transfer in flight at a time, with a watchdog that aborts hung slaves.
module avalon_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] av_address,
  output logic        av_read,
  output logic        av_write,
  output logic [31:0] av_writedata,
  output logic [3:0]  av_byteenable,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        stall,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2
  } state_t;

  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state;
  logic             last_d;
  logic [CNT_W-1:0] wd_cnt;

  logic want_i;
  logic want_d;
  logic pick_i;
  logic pick_d;
  logic wd_fire;
  logic done;

  // A requester whose ack is high is still showing its old req.
  assign want_i = i_req & ~i_ack;
  assign want_d = d_req & ~d_ack;

  assign pick_i = want_i & (~want_d | last_d);
  assign pick_d = want_d & (~want_i | ~last_d);

  assign wd_fire = WD_EN & av_waitrequest & (wd_cnt == WD_LAST);
  assign done    = ~av_waitrequest | wd_fire;

  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_d        <= 1'b1;
      wd_cnt        <= '0;
      av_address    <= '0;
      av_read       <= 1'b0;
      av_write      <= 1'b0;
      av_writedata  <= '0;
      av_byteenable <= '0;
      i_rdata       <= '0;
      i_ack         <= 1'b0;
      d_rdata       <= '0;
      d_ack         <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_i) begin
            state         <= BUS_I;
            av_address    <= i_addr;
            av_read       <= 1'b1;
            av_write      <= 1'b0;
            av_writedata  <= '0;
            av_byteenable <= 4'hF;
          end else if (pick_d) begin
            state         <= BUS_D;
            av_address    <= d_addr;
            av_read       <= ~d_write;
            av_write      <= d_write;
            av_writedata  <= d_wdata;
            av_byteenable <= d_be;
          end
        end
        BUS_I, BUS_D: begin
          if (!done) begin
            if (WD_EN) wd_cnt <= wd_cnt + 1'b1;
          end else begin
            state    <= IDLE;
            av_read  <= 1'b0;
            av_write <= 1'b0;
            wd_cnt   <= '0;
            last_d   <= (state == BUS_D);
            if (wd_fire) timeout_err <= 1'b1;
            if (state == BUS_I) begin
              i_ack   <= 1'b1;
              i_rdata <= wd_fire ? 32'hFFFF_FFFF : av_readdata;
            end else begin
              d_ack <= 1'b1;
              if (wd_fire)
                d_rdata <= 32'hFFFF_FFFF;
              else if (av_read)
                d_rdata <= av_readdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_port_arbiter.sv
// Bench for avalon_port_arbiter: directed traffic, transaction model,
// per-cycle output compare and literal timing expectations.
module tb_avalon_port_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        av_waitrequest = 1'b0;
  logic [31:0] av_readdata = '0;
  logic        stall;
  logic        timeout_err;

  int n_checks = 0;
  int n_err = 0;

  avalon_port_arbiter #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(3)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be), .d_rdata(d_rdata), .d_ack(d_ack),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .stall(stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: owner 0 = bus free, 1 = fetch, 2 = data.
  int          m_owner;
  int          m_wait;
  logic        m_last_d;
  logic [31:0] e_addr, e_wd, e_i_rdata, e_d_rdata;
  logic [3:0]  e_be;
  logic        e_rd, e_wr, e_i_ack, e_d_ack, e_terr;
  logic        m_want_i, m_want_d;

  assign m_want_i = i_req && !e_i_ack;
  assign m_want_d = d_req && !e_d_ack;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= 0; m_wait <= 0; m_last_d <= 1'b1;
      e_addr <= '0; e_wd <= '0; e_be <= '0; e_rd <= 1'b0; e_wr <= 1'b0;
      e_i_ack <= 1'b0; e_d_ack <= 1'b0;
      e_i_rdata <= '0; e_d_rdata <= '0; e_terr <= 1'b0;
    end else begin
      e_i_ack <= 1'b0;
      e_d_ack <= 1'b0;
      if (m_owner == 0) begin
        if (m_want_i && (!m_want_d || m_last_d)) begin
          m_owner <= 1; e_addr <= i_addr; e_rd <= 1'b1; e_wr <= 1'b0;
          e_be <= 4'hF;
        end else if (m_want_d) begin
          m_owner <= 2; e_addr <= d_addr; e_rd <= !d_write;
          e_wr <= d_write; e_be <= d_be; e_wd <= d_wdata;
        end
      end else if (av_waitrequest && !(TMO != 0 && m_wait + 1 == TMO)) begin
        m_wait <= m_wait + 1;
      end else begin
        m_owner <= 0; m_wait <= 0; e_rd <= 1'b0; e_wr <= 1'b0;
        m_last_d <= (m_owner == 2);
        if (av_waitrequest) begin
          e_terr <= 1'b1;
          if (m_owner == 1) e_i_rdata <= 32'hFFFF_FFFF;
          else e_d_rdata <= 32'hFFFF_FFFF;
        end else if (m_owner == 1) begin
          e_i_rdata <= av_readdata;
        end else if (e_rd) begin
          e_d_rdata <= av_readdata;
        end
        if (m_owner == 1) e_i_ack <= 1'b1;
        else e_d_ack <= 1'b1;
      end
    end
  end

  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic prev_strobe = 1'b0;
  int   glog[$];

  always @(negedge clk) begin
    chk("av_read", av_read, e_rd);
    chk("av_write", av_write, e_wr);
    chk("i_ack", i_ack, e_i_ack);
    chk("d_ack", d_ack, e_d_ack);
    chk("i_rdata", i_rdata, e_i_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("timeout_err", timeout_err, e_terr);
    chk("stall", stall, (i_req && !e_i_ack) || (d_req && !e_d_ack));
    if (e_rd || e_wr) begin
      chk("av_address", av_address, e_addr);
      chk("av_byteenable", av_byteenable, e_be);
    end
    if (e_wr) chk("av_writedata", av_writedata, e_wd);
    if (av_read) rd_cnt <= rd_cnt + 1;
    if (av_write) wr_cnt <= wr_cnt + 1;
    if ((av_read || av_write) && !prev_strobe)
      glog.push_back(av_address[11] ? 1 : 0);
    prev_strobe <= av_read || av_write;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int r0, w0, g0, ni, nd, cyc, first_i, first_d;
    int exp_g[6];
    exp_g = '{0, 1, 0, 1, 0, 1};
    #1;
    chk("rst_av_read", av_read, 0);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_stall", stall, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // single fetch
    i_addr = 32'hBFC0_0000; i_req = 1'b1;
    av_readdata = 32'h2402_0005; r0 = rd_cnt;
    tick();
    chk("f_c1_read", av_read, 1);
    chk("f_c1_addr", av_address, 32'hBFC0_0000);
    tick();
    chk("f_c2_ack", i_ack, 1);
    chk("f_c2_rdata", i_rdata, 32'h2402_0005);
    i_req = 1'b0;
    tick();
    chk("f_c3_ack", i_ack, 0);
    chk("f_reads", rd_cnt - r0, 1);

    // data write with 3 wait states
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h1000;
    d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; av_waitrequest = 1'b1;
    w0 = wr_cnt;
    #1 chk("w_c0_stall", stall, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("w_stall", stall, 1);
      chk("w_write", av_write, 1);
      chk("w_addr", av_address, 32'h1000);
      chk("w_data", av_writedata, 32'hDEAD_BEEF);
      chk("w_be", av_byteenable, 4'b0011);
      chk("w_noack", d_ack, 0);
      if (k == 4) av_waitrequest = 1'b0;
    end
    tick();
    chk("w_c5_ack", d_ack, 1);
    chk("w_c5_stall", stall, 0);
    d_req = 1'b0; d_write = 1'b0;
    tick();
    chk("w_cycles", wr_cnt - w0, 4);

    // simultaneous requests, fresh reset so data was granted last
    reset = 1'b0; tick(); reset = 1'b1; tick();
    g0 = glog.size();
    i_addr = 32'h100; d_addr = 32'h800; av_readdata = 32'h55;
    i_req = 1'b1; d_req = 1'b1;
    ni = 0; nd = 0; cyc = 0; first_i = -1; first_d = -1;
    while ((i_req || d_req) && cyc < 40) begin
      tick(); cyc++;
      if (i_ack) begin
        if (first_i < 0) first_i = cyc;
        ni++;
        if (ni < 3) i_addr = i_addr + 4; else i_req = 1'b0;
      end
      if (d_ack) begin
        if (first_d < 0) first_d = cyc;
        nd++;
        if (nd < 3) d_addr = d_addr + 4; else d_req = 1'b0;
      end
    end
    chk("rr_finished", {i_req, d_req}, 0);
    chk("rr_first_i", first_i, 2);
    chk("rr_first_d", first_d, 4);
    chk("rr_grants", glog.size() - g0, 6);
    for (int k = 0; k < 6; k++)
      if (g0 + k < glog.size()) chk("rr_order", glog[g0 + k], exp_g[k]);
    tick();

    // stale request mask
    r0 = rd_cnt; i_addr = 32'h200; i_req = 1'b1;
    tick(); chk("s_c1_read", av_read, 1);
    tick(); chk("s_c2_ack", i_ack, 1);
    tick();
    chk("s_c3_read", av_read, 0);
    chk("s_c3_ack", i_ack, 0);
    chk("s_one_read", rd_cnt - r0, 1);
    tick(); chk("s_c4_read", av_read, 1);
    tick(); chk("s_c5_ack", i_ack, 1);
    i_req = 1'b0;
    tick();

    // watchdog on a data read
    d_write = 1'b0; d_addr = 32'h840; d_req = 1'b1; av_waitrequest = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t_read", av_read, 1);
      chk("t_noack", d_ack, 0);
    end
    tick();
    chk("t_drop", av_read, 0);
    chk("t_ack", d_ack, 1);
    chk("t_rdata", d_rdata, 32'hFFFF_FFFF);
    chk("t_err", timeout_err, 1);
    d_req = 1'b0; av_waitrequest = 1'b0;
    tick();
    i_addr = 32'h300; av_readdata = 32'h1234; i_req = 1'b1;
    tick(); tick();
    chk("t_good_ack", i_ack, 1);
    chk("t_good_rdata", i_rdata, 32'h1234);
    chk("t_err_sticky", timeout_err, 1);
    i_req = 1'b0;
    tick();

    // async reset in the middle of a data transfer
    d_addr = 32'h880; d_req = 1'b1; av_waitrequest = 1'b1;
    tick();
    chk("r_read", av_read, 1);
    #1 reset = 1'b0;
    #1;
    chk("r_read0", av_read, 0);
    chk("r_write0", av_write, 0);
    chk("r_dack0", d_ack, 0);
    chk("r_terr0", timeout_err, 0);
    d_req = 1'b0; av_waitrequest = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r_noack", d_ack, 0);
    end
    i_addr = 32'h400; av_readdata = 32'hABCD; i_req = 1'b1;
    tick(); chk("r_restart_read", av_read, 1);
    tick();
    chk("r_restart_ack", i_ack, 1);
    chk("r_restart_rdata", i_rdata, 32'hABCD);
    i_req = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
